// File: rtl/stream_pkg.sv
// Shared types and helpers for the packet-locked stream multiplexer.
// Holds the FSM state encoding, the arbitration mode constants and the modulo increment.
package stream_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester found scanning from ptr upward, modulo NUM_CH.
// The caller keeps ptr below NUM_CH.
module rr_arbiter
   import stream_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  grant,
   output logic              grant_valid
);

   int idx;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = int'(ptr);
      for (int k = 0; k < NUM_CH; k++) begin
         if (!grant_valid && req[idx]) begin
            grant       = SEL_W'(idx);
            grant_valid = 1'b1;
         end
         idx = wrap_inc(idx, NUM_CH);
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer that locks onto one channel for a whole packet and
// re-arbitrates (round-robin or external select) only after that packet's last beat.
module stream_mux_rr
   import stream_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 8,
   parameter int SEL_W    = $clog2(NUM_CH),
   parameter int ARB_MODE = ARB_RR
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH-1:0]        in_last,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [SEL_W-1:0]         sel_in,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   output logic                     out_last,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready,
   output state_t                   fsm_state
);

   // Handshake: a beat transfers on a rising edge where valid && ready are both high;
   // valid never waits on ready, and a producer holds its beat until it transfers.

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  grant_q, grant_d;
   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [SEL_W-1:0]  arb_grant;
   logic              arb_valid;
   logic [SEL_W-1:0]  win;
   logic              win_valid;

   logic              grant_in_valid;
   logic              grant_last;
   logic [DATA_W-1:0] grant_data;
   logic              slot_free;
   logic              accept;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_arb (
      .req         (in_valid),
      .ptr         (rr_ptr_q),
      .grant       (arb_grant),
      .grant_valid (arb_valid)
   );

   // Fixed mode ignores the arbiter; an out-of-range sel_in simply matches no channel.
   always_comb begin
      win       = arb_grant;
      win_valid = arb_valid;
      if (ARB_MODE == ARB_FIXED) begin
         win       = sel_in;
         win_valid = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel_in == SEL_W'(i) && in_valid[i]) win_valid = 1'b1;
         end
      end
   end

   always_comb begin
      grant_in_valid = 1'b0;
      grant_last     = 1'b0;
      grant_data     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_q == SEL_W'(i)) begin
            grant_in_valid = in_valid[i];
            grant_last     = in_last[i];
            grant_data     = in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign slot_free = !out_valid || out_ready;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      in_ready = '0;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               grant_d = win;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (grant_q == SEL_W'(i)) in_ready[i] = slot_free;
            end
            accept = grant_in_valid && slot_free;
            if (accept && grant_last) begin
               state_d  = IDLE;
               rr_ptr_d = SEL_W'(wrap_inc(int'(grant_q), NUM_CH));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // A simultaneous upstream and downstream accept reloads the register and keeps valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_ch    <= '0;
      end else if (accept) begin
         out_data  <= grant_data;
         out_valid <= 1'b1;
         out_last  <= grant_last;
         out_ch    <= grant_q;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign fsm_state = state_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel round-robin instance and a 5-channel fixed-select instance
// share one set of channel drivers; expected beats come from a packet-level reference model.
module tb_stream_mux_rr;
   import stream_pkg::*;

   localparam int MAXCH = 5;
   localparam int RR_CH = 4;
   localparam int DW    = 8;
   localparam int EXP_W = 3 + 1 + DW;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          first;
   } beat_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [MAXCH*DW-1:0] in_data;
   logic [MAXCH-1:0]    in_valid;
   logic [MAXCH-1:0]    in_last;
   logic [2:0]          sel_in;
   logic                out_ready;
   logic                dut_sel;

   logic [RR_CH-1:0] rr_in_ready;
   logic [DW-1:0]    rr_out_data;
   logic             rr_out_valid, rr_out_last;
   logic [1:0]       rr_out_ch;
   state_t           rr_state;

   logic [MAXCH-1:0] fx_in_ready;
   logic [DW-1:0]    fx_out_data;
   logic             fx_out_valid, fx_out_last;
   logic [2:0]       fx_out_ch;
   state_t           fx_state;

   logic [MAXCH-1:0] in_ready;
   logic [DW-1:0]    out_data;
   logic             out_valid, out_last;
   logic [2:0]       out_ch;
   state_t           fsm_state;

   stream_mux_rr #(.NUM_CH(RR_CH), .DATA_W(DW), .ARB_MODE(ARB_RR)) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data[RR_CH*DW-1:0]),
      .in_valid  (dut_sel ? {RR_CH{1'b0}} : in_valid[RR_CH-1:0]),
      .in_last   (in_last[RR_CH-1:0]),
      .in_ready  (rr_in_ready),
      .sel_in    (sel_in[1:0]),
      .out_data  (rr_out_data),
      .out_valid (rr_out_valid),
      .out_last  (rr_out_last),
      .out_ch    (rr_out_ch),
      .out_ready (out_ready),
      .fsm_state (rr_state)
   );

   stream_mux_rr #(.NUM_CH(MAXCH), .DATA_W(DW), .ARB_MODE(ARB_FIXED)) u_fix (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (dut_sel ? in_valid : {MAXCH{1'b0}}),
      .in_last   (in_last),
      .in_ready  (fx_in_ready),
      .sel_in    (sel_in),
      .out_data  (fx_out_data),
      .out_valid (fx_out_valid),
      .out_last  (fx_out_last),
      .out_ch    (fx_out_ch),
      .out_ready (out_ready),
      .fsm_state (fx_state)
   );

   assign in_ready  = dut_sel ? fx_in_ready  : {1'b0, rr_in_ready};
   assign out_data  = dut_sel ? fx_out_data  : rr_out_data;
   assign out_valid = dut_sel ? fx_out_valid : rr_out_valid;
   assign out_last  = dut_sel ? fx_out_last  : rr_out_last;
   assign out_ch    = dut_sel ? fx_out_ch    : {1'b0, rr_out_ch};
   assign fsm_state = dut_sel ? fx_state     : rr_state;

   // ---------------- bench state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [EXP_W-1:0] exp_q[$];
   beat_t ch_q[MAXCH][$];
   beat_t m_q[MAXCH][$];
   int model_ptr   = 0;
   int hold_cnt    = 0;
   bit rdy_rand    = 1'b0;
   bit gaps_en     = 1'b0;
   bit spacing_chk = 1'b0;
   int cyc         = 0;
   bit last_done   = 1'b0;
   bit stalled     = 1'b0;
   int last_hs     = -1;
   logic [EXP_W-1:0] held;
   logic [EXP_W-1:0] got;
   logic [EXP_W-1:0] want;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pending();
      int s = 0;
      for (int c = 0; c < MAXCH; c++) s += ch_q[c].size();
      return s;
   endfunction

   // dmode: 0 = constant d0, 1 = d0*(beat+1), 2 = random
   task automatic load_pkt(input int c, input int len, input logic [DW-1:0] d0, input int dmode);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data  = (dmode == 0) ? d0 : (dmode == 1) ? DW'(d0 * (i + 1)) : DW'($urandom_range(0, 255));
         b.last  = (i == len - 1);
         b.first = (i == 0);
         ch_q[c].push_back(b);
         m_q[c].push_back(b);
      end
   endtask

   // Reference: whole packets, each won by the first pending channel at or after the pointer.
   task automatic model_rr();
      int w;
      beat_t b;
      forever begin
         w = -1;
         for (int k = 0; k < RR_CH; k++) begin
            if (w < 0 && m_q[(model_ptr + k) % RR_CH].size() > 0) w = (model_ptr + k) % RR_CH;
         end
         if (w < 0) break;
         do begin
            b = m_q[w].pop_front();
            exp_q.push_back({3'(w), b.last, b.data});
         end while (!b.last);
         model_ptr = (w + 1) % RR_CH;
      end
   endtask

   task automatic model_fixed(input int c);
      beat_t b;
      do begin
         b = m_q[c].pop_front();
         exp_q.push_back({3'(c), b.last, b.data});
      end while (!b.last);
   endtask

   task automatic tick();
      @(negedge clk);
      #4;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || pending() != 0) && t < 2000) begin
         tick();
         t++;
      end
      check({name, "_drained"}, 32'(exp_q.size() + pending()), 0);
      tick();
      tick();
   endtask

   task automatic wait_out_valid(input string name);
      int t = 0;
      while (!out_valid && t < 100) begin
         tick();
         t++;
      end
      check({name, "_out_valid_seen"}, 32'(out_valid), 1);
   endtask

   // ---------------- driver ----------------
   initial begin : driver
      in_valid  = '0;
      in_last   = '0;
      in_data   = '0;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < MAXCH; c++) begin
            in_valid[c]          = 1'b0;
            in_last[c]           = 1'b0;
            in_data[c*DW +: DW]  = DW'($urandom_range(0, 255));
            if (ch_q[c].size() > 0) begin
               if (!(gaps_en && !ch_q[c][0].first && $urandom_range(0, 3) == 0)) begin
                  in_valid[c]         = 1'b1;
                  in_last[c]          = ch_q[c][0].last;
                  in_data[c*DW +: DW] = ch_q[c][0].data;
               end
            end
         end
         if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
         end else begin
            out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         #3;
         if (rst_n) begin
            if (last_done) check("idle_after_last", 32'(in_ready), 0);
            last_done = 1'b0;
            check("ready_at_most_one", 32'($countones(in_ready) <= 1), 1);
            if (out_valid && !out_ready) check("stall_in_ready_low", 32'(in_ready), 0);
            for (int c = 0; c < MAXCH; c++) begin
               if (in_valid[c] && in_ready[c]) begin
                  if (ch_q[c][0].last) last_done = 1'b1;
                  void'(ch_q[c].pop_front());
               end
            end
         end else begin
            last_done = 1'b0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      forever begin
         @(negedge clk);
         #3;
         cyc++;
         if (!rst_n) begin
            stalled = 1'b0;
            last_hs = -1;
         end else begin
            got = {out_ch, out_last, out_data};
            if (stalled) check("stall_stable", 32'(got), 32'(held));
            stalled = out_valid && !out_ready;
            held    = got;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got %0h, no beat expected (t=%0t)", got, $time);
               end else begin
                  want = exp_q.pop_front();
                  check("beat", 32'(got), 32'(want));
               end
               if (spacing_chk && last_hs >= 0) check("single_beat_spacing", 32'(cyc - last_hs), 2);
               last_hs = cyc;
            end
            if (!spacing_chk) last_hs = -1;
         end
      end
   end

   // ---------------- stimulus sequence ----------------
   initial begin : main
      dut_sel = 1'b0;
      sel_in  = '0;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_out_ch", 32'(out_ch), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      #1 rst_n = 1'b1;
      tick();
      check("post_rst_state", 32'(fsm_state), 32'(IDLE));
      check("post_rst_in_ready", 32'(in_ready), 0);

      // round-robin fairness: every channel busy with 2-beat packets
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < RR_CH; c++) load_pkt(c, 2, DW'(8'hA0 + c), 0);
      model_rr();
      drain("rr_fair");

      // wrap and skip: leave the pointer at 2, then only channels 1 and 3 request
      load_pkt(1, 2, 8'h00, 2);
      model_rr();
      drain("wrap_setup");
      load_pkt(1, 2, 8'h00, 2);
      load_pkt(3, 3, 8'h00, 2);
      model_rr();
      drain("wrap_skip");

      // backpressure mid-packet on channel 2
      load_pkt(2, 3, 8'h11, 1);
      model_rr();
      wait_out_valid("bp");
      hold_cnt = 5;
      drain("backpressure");

      // randomized traffic with gaps and random downstream ready
      rdy_rand = 1'b1;
      gaps_en  = 1'b1;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < RR_CH; c++) begin
            int n = $urandom_range(0, 2);
            for (int p = 0; p < n; p++) load_pkt(c, $urandom_range(1, 4), 8'h00, 2);
         end
         model_rr();
         drain("random");
      end
      rdy_rand = 1'b0;
      gaps_en  = 1'b0;

      // asynchronous reset while a stalled beat is pending
      load_pkt(0, 6, 8'h00, 2);
      model_rr();
      hold_cnt = 1000;
      wait_out_valid("rst_mid");
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_out_data", 32'(out_data), 0);
      check("midrst_out_last", 32'(out_last), 0);
      check("midrst_out_ch", 32'(out_ch), 0);
      check("midrst_in_ready", 32'(in_ready), 0);
      hold_cnt = 0;
      exp_q.delete();
      for (int c = 0; c < MAXCH; c++) begin
         ch_q[c].delete();
         m_q[c].delete();
      end
      model_ptr = 0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("midrst_state_idle", 32'(fsm_state), 32'(IDLE));
      check("midrst_no_beat", 32'(out_valid), 0);
      check("midrst_ready_zero", 32'(in_ready), 0);

      // back-to-back single-beat packets on channel 1
      spacing_chk = 1'b1;
      for (int p = 0; p < 6; p++) load_pkt(1, 1, 8'h00, 2);
      model_rr();
      drain("single_beat");
      spacing_chk = 1'b0;

      // fixed select: sel_in=2, then changed to 0 mid-packet
      dut_sel = 1'b1;
      sel_in  = 3'd2;
      gaps_en = 1'b1;
      load_pkt(0, 3, 8'h00, 2);
      load_pkt(2, 4, 8'h00, 2);
      model_fixed(2);
      model_fixed(0);
      wait_out_valid("fixed");
      sel_in = 3'd0;
      drain("fixed_sel");
      gaps_en = 1'b0;

      // out-of-range select grants nothing
      sel_in = 3'd5;
      load_pkt(3, 2, 8'h00, 2);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("nogrant_in_ready", 32'(in_ready), 0);
         check("nogrant_out_valid", 32'(out_valid), 0);
         check("nogrant_state", 32'(fsm_state), 32'(IDLE));
      end
      sel_in = 3'd3;
      model_fixed(3);
      drain("fixed_after_nogrant");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

endmodule
